serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor/adder built around the single-bit full-subtractor cell of the arithmetic library, generalised to a parametrised operand width and an add/subtract mode. It processes one bit pair per clock, LSB first, with a registered borrow/carry. It trades latency for area. It sits in the arithmetic chapter as the sequential successor to the combinational subtractors, with a start/busy/done handshake for use by a controlling FSM.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- mode  input  1  0 = subtract (a - b), 1 = add (a + b); captured with start
- a  input  WIDTH  minuend/addend; captured with start
- b  input  WIDTH  subtrahend/addend; captured with start
- result  output  WIDTH  difference/sum of the last completed operation
- bor_out  output  1  final borrow (mode 0) or final carry (mode 1) of the last completed operation
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result/bor_out have just been updated

## Operation
- Reset values: state IDLE, result = 0, bor_out = 0, busy = 0, done = 0, internal shift registers, borrow flop and bit counter = 0.
- States: IDLE, RUN, DONE.
- IDLE: start = 1 -> load a, b and mode into internal registers, clear borrow/carry flop, clear counter, go to RUN. start = 0 -> stay.
- RUN: each cycle take bit x = a_sh[0], y = b_sh[0], c = borrow/carry flop:
  - mode 0: d = x ^ y ^ c; c_next = (~x & y) | (~x & c) | (y & c)
  - mode 1: d = x ^ y ^ c; c_next = (x & y) | (x & c) | (y & c)
  - shift a_sh, b_sh right by one; shift d into MSB of the internal result shift register; counter increments.
  - After the WIDTH-th bit (counter = WIDTH-1): load result from the completed shift register, bor_out from c_next, go to DONE.
- DONE: done = 1 for exactly this cycle. start = 1 -> same capture as IDLE, go to RUN (back-to-back); else go to IDLE.
- start and input changes while in RUN are ignored; operands are fully registered at capture.
- result and bor_out change only on the RUN -> DONE transition; they hold their value through IDLE and through the whole of a following operation.
- Arithmetic is modulo 2^WIDTH: mode 0 with a < b wraps (two's-complement difference) and sets bor_out = 1; mode 1 overflow wraps and sets bor_out = 1.
- Counter width is clog2(WIDTH); no wrap beyond WIDTH-1 occurs.

## Timing
- Cycle 0: start = 1 sampled (IDLE or DONE). Cycles 1..WIDTH: busy = 1, one bit per cycle. Cycle WIDTH+1: state DONE, done = 1, busy = 0, result/bor_out valid.
- Latency start-sample to done = WIDTH+1 cycles. Throughput with back-to-back start: one result per WIDTH+1 cycles.
- busy and done are never high together; done never high two consecutive cycles.
- rst asserted at any time (including mid-RUN) -> all outputs and state return to reset values immediately; the operation in progress is lost; no done pulse follows. First start is sampled on the first clk edge after rst deasserts.

## Test plan
- WIDTH=8, mode 0, a=0x5A, b=0x3C -> busy 8 cycles, done on cycle 9, result=0x1E, bor_out=0.
- mode 0, a=0x3C, b=0x5A -> result=0xE2, bor_out=1; a=0x00, b=0x01 -> result=0xFF, bor_out=1.
- mode 1, a=0xFF, b=0x01 -> result=0x00, bor_out=1; a=0x12, b=0x34 -> result=0x46, bor_out=0.
- Start 0x5A-0x3C, then pulse start with a=0xFF, b=0xFF during RUN -> ignored; result=0x1E. Start again in the done cycle with a=0x10, b=0x01 -> busy next cycle, second done 9 cycles later, result=0x0F; result stays 0x1E throughout the second run.
- Assert rst in cycle 4 of a run -> result=0, bor_out=0, busy=0, done=0 immediately; no done pulse. After release, 0x01-0x02 -> result=0xFF, bor_out=1.
- Random sweep, WIDTH=8 and WIDTH=16, both modes -> result and bor_out match a reference model computing modulo 2^WIDTH, done exactly WIDTH+1 cycles after each accepted start.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand bus for the bit-serial subtractor/adder.
// The master owns start/mode/a/b; the slave returns result, bor_out, busy and done.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             bor_out;
    logic             busy;
    logic             done;

    modport master (output start, mode, a, b, input result, bor_out, busy, done);
    modport slave  (input start, mode, a, b, output result, bor_out, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor/adder: one bit pair per clock, LSB first,
// registered borrow/carry, start/busy/done handshake.
module serial_sub_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    input  logic mode,
    output logic d,
    output logic c_next
);
    // Adding is subtracting with the minuend bit inverted in the borrow term.
    logic xe;
    assign xe     = mode ? x : ~x;
    assign d      = x ^ y ^ c;
    assign c_next = (xe & y) | (xe & c) | (y & c);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             c_q;
    logic             bor_q;
    logic             busy_q;
    logic             done_q;
    logic             d;
    logic             c_next;

    serial_sub_cell u_cell (
        .x      (a_sh[0]),
        .y      (b_sh[0]),
        .c      (c_q),
        .mode   (mode_q),
        .d      (d),
        .c_next (c_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            result_q <= '0;
            cnt      <= '0;
            mode_q   <= 1'b0;
            c_q      <= 1'b0;
            bor_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        mode_q <= bus.mode;
                        c_q    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= {d, r_sh[WIDTH-1:1]};
                    c_q  <= c_next;
                    if (cnt == LAST) begin
                        // Outputs only move here, so they hold across the next run.
                        result_q <= {d, r_sh[WIDTH-1:1]};
                        bor_q    <= c_next;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.bor_out = bor_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and reference-model checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  s8 ();
    serial_subtractor_if #(.WIDTH(16)) s16 ();

    serial_subtractor #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(s8));
    serial_subtractor #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(s16));

    // Runs one op from IDLE/DONE; returns in the done cycle (or after the bound).
    // bad counts cycles where result moved mid-run or busy and done overlapped.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic m,
                          output logic [7:0] r, output logic bo,
                          output int lat, output int bcnt, output int bad);
        logic [7:0] r0;
        r0 = s8.result;
        s8.start = 1'b1; s8.a = av; s8.b = bv; s8.mode = m;
        @(posedge clk); #1;
        s8.start = 1'b0; s8.a = 8'($urandom); s8.b = 8'($urandom); s8.mode = ~m;
        lat = 1; bcnt = 0; bad = 0;
        while (!s8.done && lat < 40) begin
            if (s8.busy) bcnt++;
            if (s8.result !== r0) bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (s8.busy) bad++;
        r = s8.result; bo = s8.bor_out;
    endtask

    task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic m,
                           output logic [15:0] r, output logic bo, output int lat);
        s16.start = 1'b1; s16.a = av; s16.b = bv; s16.mode = m;
        @(posedge clk); #1;
        s16.start = 1'b0; s16.a = 16'($urandom); s16.b = 16'($urandom);
        lat = 1;
        while (!s16.done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        r = s16.result; bo = s16.bor_out;
    endtask

    task automatic test_reset();
        s8.start = 1'b0; s8.mode = 1'b0; s8.a = '0; s8.b = '0;
        s16.start = 1'b0; s16.mode = 1'b0; s16.a = '0; s16.b = '0;
        rst = 1'b1;
        #2;
        checks++; if (s8.result !== 8'h00) begin errors++; $display("FAIL reset result: got %h want 00", s8.result); end
        checks++; if (s8.bor_out !== 1'b0) begin errors++; $display("FAIL reset bor_out: got %b want 0", s8.bor_out); end
        checks++; if (s8.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", s8.busy); end
        checks++; if (s8.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", s8.done); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [7:0] ta [5] = '{8'h5A, 8'h3C, 8'h00, 8'hFF, 8'h12};
        logic [7:0] tb [5] = '{8'h3C, 8'h5A, 8'h01, 8'h01, 8'h34};
        logic       tm [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        logic [7:0] tr [5] = '{8'h1E, 8'hE2, 8'hFF, 8'h00, 8'h46};
        logic       tc [5] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [7:0] r; logic bo; int lat, bcnt, bad;
        for (int i = 0; i < 5; i++) begin
            do_op8(ta[i], tb[i], tm[i], r, bo, lat, bcnt, bad);
            checks++; if (r !== tr[i]) begin errors++; $display("FAIL arith%0d result: got %h want %h", i, r, tr[i]); end
            checks++; if (bo !== tc[i]) begin errors++; $display("FAIL arith%0d bor_out: got %b want %b", i, bo, tc[i]); end
            checks++; if (lat != 9) begin errors++; $display("FAIL arith%0d latency: got %0d want 9", i, lat); end
            checks++; if (bcnt != 8) begin errors++; $display("FAIL arith%0d busy cycles: got %0d want 8", i, bcnt); end
            checks++; if (bad != 0) begin errors++; $display("FAIL arith%0d hold/overlap: got %0d want 0", i, bad); end
        end
        @(posedge clk); #1;
        checks++; if (s8.done !== 1'b0) begin errors++; $display("FAIL done width: got %b want 0", s8.done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r; logic bo; int lat, bcnt, bad;
        s8.start = 1'b1; s8.a = 8'h5A; s8.b = 8'h3C; s8.mode = 1'b0;
        @(posedge clk); #1;
        s8.start = 1'b0;
        @(posedge clk); #1;
        s8.start = 1'b1; s8.a = 8'hFF; s8.b = 8'hFF; s8.mode = 1'b1;
        @(posedge clk); #1;
        s8.start = 1'b0;
        lat = 3;
        while (!s8.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL ignore latency: got %0d want 9", lat); end
        checks++; if (s8.result !== 8'h1E) begin errors++; $display("FAIL ignore result: got %h want 1e", s8.result); end
        checks++; if (s8.bor_out !== 1'b0) begin errors++; $display("FAIL ignore bor_out: got %b want 0", s8.bor_out); end
        do_op8(8'h10, 8'h01, 1'b0, r, bo, lat, bcnt, bad);
        checks++; if (r !== 8'h0F) begin errors++; $display("FAIL b2b result: got %h want 0f", r); end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b latency: got %0d want 9", lat); end
        checks++; if (bcnt != 8) begin errors++; $display("FAIL b2b busy cycles: got %0d want 8", bcnt); end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b result hold: got %0d want 0", bad); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] r; logic bo; int lat, bcnt, bad, dcnt;
        s8.start = 1'b1; s8.a = 8'h5A; s8.b = 8'h3C; s8.mode = 1'b0;
        @(posedge clk); #1;
        s8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++; if (s8.result !== 8'h00) begin errors++; $display("FAIL midrst result: got %h want 00", s8.result); end
        checks++; if (s8.bor_out !== 1'b0) begin errors++; $display("FAIL midrst bor_out: got %b want 0", s8.bor_out); end
        checks++; if (s8.busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b want 0", s8.busy); end
        checks++; if (s8.done !== 1'b0) begin errors++; $display("FAIL midrst done: got %b want 0", s8.done); end
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8.done || s8.busy) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL midrst activity after reset: got %0d want 0", dcnt); end
        do_op8(8'h01, 8'h02, 1'b0, r, bo, lat, bcnt, bad);
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL postrst result: got %h want ff", r); end
        checks++; if (bo !== 1'b1) begin errors++; $display("FAIL postrst bor_out: got %b want 1", bo); end
        checks++; if (lat != 9) begin errors++; $display("FAIL postrst latency: got %0d want 9", lat); end
    endtask

    task automatic test_sweep();
        logic [7:0] a8, b8, r8; logic [15:0] a16, b16, r16;
        logic [8:0] e8; logic [16:0] e16;
        logic m, bo; int lat, bcnt, bad;
        for (int i = 0; i < 8; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); m = 1'($urandom);
            e8 = m ? ({1'b0, a8} + {1'b0, b8}) : ({1'b0, a8} - {1'b0, b8});
            do_op8(a8, b8, m, r8, bo, lat, bcnt, bad);
            checks++; if ({bo, r8} !== e8 || lat != 9) begin
                errors++; $display("FAIL sweep8 %h %s %h: got %b_%h lat %0d want %b_%h lat 9",
                                   a8, m ? "+" : "-", b8, bo, r8, lat, e8[8], e8[7:0]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); m = 1'(i);
            e16 = m ? ({1'b0, a16} + {1'b0, b16}) : ({1'b0, a16} - {1'b0, b16});
            do_op16(a16, b16, m, r16, bo, lat);
            checks++; if ({bo, r16} !== e16 || lat != 17) begin
                errors++; $display("FAIL sweep16 %h %s %h: got %b_%h lat %0d want %b_%h lat 17",
                                   a16, m ? "+" : "-", b16, bo, r16, lat, e16[16], e16[15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
